// File: rtl/dsd_dec_pkg.sv
// Shared types and helpers for the 3-to-8 scan decoder.
// Holds the FSM state enum and the one-hot decode function.
package dsd_dec_pkg;

  typedef enum logic [1:0] {
    DIRECT = 2'd0,
    SCAN   = 2'd1,
    DRAIN  = 2'd2
  } dec_state_t;

  function automatic logic [7:0] onehot3(input logic [2:0] c);
    onehot3 = 8'b1 << c;
  endfunction

endpackage

// File: rtl/decoder3x8_scan_tick.sv
// Scan step divider: counts 0..DIV-1 and flags the terminal count.
// Holds at terminal while the output side is stalled.
module scan_tick
  import dsd_dec_pkg::*;
#(
  parameter int unsigned DIV = 4
) (
  input  logic clk,
  input  logic rst_n,
  input  logic clr,
  input  logic hold,
  output logic tick
);

  localparam int unsigned W = (DIV > 1) ? $clog2(DIV) : 1;
  localparam logic [W-1:0] TERM = W'(DIV - 1);

  logic [W-1:0] cnt_q;
  logic [W-1:0] cnt_d;

  assign tick = (cnt_q == TERM);

  // Next count: clear, advance, or wrap at terminal unless stalled.
  always_comb begin
    cnt_d = cnt_q;
    if (clr) begin
      cnt_d = '0;
    end else if (!tick) begin
      cnt_d = cnt_q + W'(1);
    end else if (!hold) begin
      cnt_d = '0;
    end
  end

  // Counter register.
  always_ff @(posedge clk or negedge rst_n) begin
    if (!rst_n) begin
      cnt_q <= '0;
    end else begin
      cnt_q <= cnt_d;
    end
  end

endmodule

// File: rtl/decoder3x8_scan.sv
// Registered 3-to-8 one-hot decoder with valid/ready on both sides.
// Scan mode walks the eight outputs on its own for display muxing.
module decoder3x8_scan
  import dsd_dec_pkg::*;
#(
  parameter int unsigned SCAN_DIV = 4
) (
  input  logic       clk,
  input  logic       rst_n,
  input  logic       mode,
  input  logic       in_valid,
  output logic       in_ready,
  input  logic [2:0] code,
  output logic       out_valid,
  input  logic       out_ready,
  output logic [7:0] data,
  output logic [2:0] scan_idx
);

  dec_state_t state_q, state_d;
  logic [7:0] data_q, data_d;
  logic       valid_q, valid_d;
  logic [2:0] idx_q, idx_d;
  logic       tick;
  logic       xfer;
  logic       room;

  assign xfer      = valid_q && out_ready;
  assign room      = !valid_q || out_ready;
  assign in_ready  = (state_q == DIRECT) && !mode && room;
  assign out_valid = valid_q;
  assign data      = data_q;
  assign scan_idx  = idx_q;

  scan_tick #(
    .DIV (SCAN_DIV)
  ) u_tick (
    .clk   (clk),
    .rst_n (rst_n),
    .clr   (state_q != SCAN),
    .hold  (valid_q && !out_ready),
    .tick  (tick)
  );

  // Next state, output word and scan index.
  always_comb begin
    state_d = state_q;
    data_d  = data_q;
    valid_d = valid_q && !xfer;
    idx_d   = idx_q;
    unique case (state_q)
      DIRECT: begin
        if (mode) begin
          state_d = DRAIN;
        end else if (in_valid && in_ready) begin
          data_d  = onehot3(code);
          valid_d = 1'b1;
        end
      end
      SCAN: begin
        if (!mode) begin
          state_d = DRAIN;
          idx_d   = 3'd0;
        end else if (tick && room) begin
          data_d  = onehot3(idx_q);
          valid_d = 1'b1;
          idx_d   = idx_q + 3'd1;
        end
      end
      DRAIN: begin
        if (room) begin
          state_d = mode ? SCAN : DIRECT;
        end
      end
      default: begin
        state_d = DIRECT;
      end
    endcase
  end

  // State and output registers; reset drops any pending word.
  always_ff @(posedge clk or negedge rst_n) begin
    if (!rst_n) begin
      state_q <= DIRECT;
      data_q  <= 8'h00;
      valid_q <= 1'b0;
      idx_q   <= 3'd0;
    end else begin
      state_q <= state_d;
      data_q  <= data_d;
      valid_q <= valid_d;
      idx_q   <= idx_d;
    end
  end

endmodule

// File: doc/decoder3x8_scan.md
# decoder3x8_scan

Registered 3-to-8 one-hot decoder with valid/ready handshakes on both sides and a self-timed scan mode. It is the inverse of the team's 8-to-3 one-hot encoder: a code `c` becomes `data = 1 << c`. It sits between a code source (or the encoder output) and one-hot consumers such as 7-segment digit selects. In scan mode it walks the eight outputs on its own, for display multiplexing.

## Interface
- `SCAN_DIV`, default 4: cycles per scan step. Legal range 1..256.
- `clk`, input, 1: single clock; all logic is rising-edge.
- `rst_n`, input, 1: asynchronous, active-low reset.
- `mode`, input, 1: 0 = direct decode, 1 = autonomous scan.
- `in_valid`, input, 1: `code` is valid.
- `in_ready`, output, 1: block accepts `code` this cycle.
- `code`, input, 3: binary index to decode.
- `out_valid`, output, 1: `data` holds a valid one-hot word.
- `out_ready`, input, 1: consumer accepts `data`.
- `data`, output, 8: registered one-hot result.
- `scan_idx`, output, 3: index of the next scan output.

## Operation
- **States:** DIRECT, SCAN, DRAIN. Reset state is DIRECT.
- **Ready rule:** `in_ready = (state==DIRECT) && !mode && (!out_valid || out_ready)`. This is combinational.
- **DIRECT accept:** when `in_valid && in_ready`, load `data <= 8'b1 << code` and set `out_valid <= 1`.
- **DIRECT release:** when `out_valid && out_ready` and there is no new accept, clear `out_valid <= 0`. `data` keeps its last value.
- **DIRECT to DRAIN:** when `mode==1` in DIRECT, go to DRAIN. No new input is accepted.
- **DRAIN exit:** leave when `!out_valid`, or when `out_valid && out_ready` (that transfer completes this cycle). Go to SCAN if `mode==1`, else DIRECT. On entry to SCAN, the divider is cleared to 0.
- **SCAN divider:** counts 0..SCAN_DIV-1. At the terminal count, if `!out_valid || out_ready`:
  - load `data <= 8'b1 << scan_idx` and set `out_valid <= 1`;
  - `scan_idx` increments, wrapping 7 to 0;
  - the divider returns to 0.
- **SCAN stall:** at the terminal count with `out_valid && !out_ready`, the divider holds at terminal. No step is skipped or lost.
- **SCAN release:** a completed transfer with no new load clears `out_valid`.
- **SCAN to DRAIN:** when `mode==0` in SCAN, go to DRAIN and set `scan_idx <= 0`. Scan always restarts at output 0.
- **Divider width:** max(1, $clog2(SCAN_DIV)). SCAN_DIV=1 gives one step per cycle under continuous `out_ready`.
- **Invariants:**
  - While `out_valid` is 1, `data` has exactly one bit set.
  - `data` and `out_valid` never change while `out_valid && !out_ready`.

## Timing
- **Reset values:** `data=8'h00`, `out_valid=0`, `scan_idx=0`, state DIRECT, divider 0. `in_ready` follows the rule above, so it is 1 when `mode==0`.
- **Reset mid-transfer:** any pending output is dropped at once, asynchronously.
- **DIRECT latency:** 1 cycle from accept to `out_valid`. Throughput is 1 code/cycle with `out_ready` held high.
- **SCAN timing:** the first output appears SCAN_DIV cycles after SCAN entry. Later outputs follow every SCAN_DIV cycles while unstalled.
- **Mode change:** `mode` is sampled every cycle. A mode pulse too short to reach DRAIN exit has no lasting effect beyond the DRAIN visit.

## Structure
- Package `dsd_dec_pkg` holds:
  - the state enum `dec_state_t` (DIRECT, SCAN, DRAIN);
  - the function `onehot3(logic [2:0]) -> logic [7:0]`.
- Sub-module `scan_tick`: a parameterised divider with inputs `clr` and `hold`, and a `tick` output at the terminal count.
- The top-level holds the FSM, the output register and `scan_idx`.

## Test plan
- **Reset, then direct decode:** `mode=0`, `out_ready=1`, present codes 0..7 back-to-back. Expect `data` = 01,02,04,…,80 on consecutive cycles, each 1 cycle after accept, with `in_ready` constantly 1.
- **Output backpressure:** `code=5` accepted, `out_ready=0` for 4 cycles. Expect `data=8'h20` and `out_valid=1` to hold stable, and `in_ready=0`. When `out_ready` rises, a simultaneous accept of `code=2` gives `data=8'h04` the next cycle.
- **Scan wrap:** SCAN_DIV=4, `mode=1`, `out_ready=1`. Expect outputs 01,02,…,80,01 every 4 cycles, the first 4 cycles after SCAN entry. `scan_idx` wraps 7 to 0.
- **Scan stall:** hold `out_ready=0` for 10 cycles during SCAN. Expect exactly one pending word, no index skipped, and the next word 0 cycles after release if the divider is already at terminal.
- **Mode switch with pending output:** in DIRECT with `out_valid=1` and `out_ready=0`, raise `mode`. Expect DRAIN, then SCAN starting at `data=8'h01` after release. Dropping `mode` mid-scan resets `scan_idx` to 0.
- **Async reset mid-scan:** assert `rst_n=0` between clock edges. Expect `out_valid` and `data` to go to 0 immediately, and state DIRECT after release.
